// File: rtl/sound_ch3_sequencer.sv
// Frame sequencer (512 Hz step, length/sweep/envelope strobes) and channel-3
// length counter, trigger and on/off control.
module sound_ch3_sequencer #(
    parameter int unsigned DIV_512 = 8192
) (
    input  logic       I_CLK,
    input  logic       I_RESET_L,
    input  logic       I_APU_EN,
    input  logic       I_DAC_EN,
    input  logic       I_NR31_WR,
    input  logic [7:0] I_NR31_DATA,
    input  logic       I_NR34_WR,
    input  logic [7:0] I_NR34_DATA,
    output logic [2:0] O_FS_STEP,
    output logic       O_LENGTH_TICK,
    output logic       O_SWEEP_TICK,
    output logic       O_ENV_TICK,
    output logic       O_CH3_TRIGGER,
    output logic       O_CH3_ON,
    output logic [8:0] O_LENGTH_COUNT
);

    localparam logic [15:0] TC_VAL = 16'(DIV_512 - 1);

    logic [15:0] prescaler;
    logic [2:0]  step;
    logic        len_en;
    logic [8:0]  len_count;

    logic        tc;
    logic        trig;
    logic        len_dec;
    logic [8:0]  len_base;
    logic [8:0]  len_next;
    logic        on_next;

    // Returns {length, sweep, envelope} tick flags for an executed step.
    function automatic logic [2:0] decode_ticks(input logic [2:0] s);
        decode_ticks[2] = ~s[0];
        decode_ticks[1] = (s == 3'd2) || (s == 3'd6);
        decode_ticks[0] = (s == 3'd7);
    endfunction

    assign tc             = (prescaler == TC_VAL);
    assign O_FS_STEP      = step;
    assign O_LENGTH_COUNT = len_count;

    always_comb begin
        trig     = I_NR34_WR & I_NR34_DATA[7];
        len_base = I_NR31_WR ? (9'd256 - {1'b0, I_NR31_DATA}) : len_count;
        // The registered length strobe drives the decrement; writes take precedence.
        len_dec  = O_LENGTH_TICK & len_en & (len_count != 9'd0) & ~I_NR31_WR & ~trig;

        len_next = len_base;
        if (trig && len_base == 9'd0)
            len_next = 9'd256;
        else if (len_dec)
            len_next = len_count - 9'd1;

        on_next = O_CH3_ON;
        if (!I_DAC_EN)
            on_next = 1'b0;
        else if (trig)
            on_next = 1'b1;
        else if (len_dec && len_count == 9'd1)
            on_next = 1'b0;
    end

    always_ff @(posedge I_CLK) begin
        if (!I_APU_EN || !I_RESET_L) begin
            prescaler     <= '0;
            step          <= '0;
            len_en        <= 1'b0;
            len_count     <= '0;
            O_LENGTH_TICK <= 1'b0;
            O_SWEEP_TICK  <= 1'b0;
            O_ENV_TICK    <= 1'b0;
            O_CH3_TRIGGER <= 1'b0;
            O_CH3_ON      <= 1'b0;
        end else begin
            prescaler <= tc ? 16'd0 : prescaler + 16'd1;
            if (tc)
                step <= step + 3'd1;
            {O_LENGTH_TICK, O_SWEEP_TICK, O_ENV_TICK} <= tc ? decode_ticks(step) : 3'b000;
            O_CH3_TRIGGER <= trig;
            O_CH3_ON      <= on_next;
            len_count     <= len_next;
            if (I_NR34_WR)
                len_en <= I_NR34_DATA[6];
        end
    end

endmodule

// File: tb/tb_sound_ch3_sequencer.sv
// Directed plus randomized bench for sound_ch3_sequencer against an
// arithmetic reference model of the frame sequencer and channel-3 rules.
module tb_sound_ch3_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       apu = 1'b1;
    logic       dac = 1'b1;
    logic       nr31_wr = 1'b0;
    logic [7:0] nr31_data = 8'h00;
    logic       nr34_wr = 1'b0;
    logic [7:0] nr34_data = 8'h00;
    logic [2:0] fs_step;
    logic       length_tick, sweep_tick, env_tick, ch3_trigger, ch3_on;
    logic [8:0] length_count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int n_pwr = 0;
    int m_count = 0;
    int m_step = 0;
    bit m_len_en = 0, m_on = 0, m_trig = 0, m_lt = 0, m_st = 0, m_et = 0;

    sound_ch3_sequencer #(.DIV_512(DIV)) dut (
        .I_CLK          (clk),
        .I_RESET_L      (rst_l),
        .I_APU_EN       (apu),
        .I_DAC_EN       (dac),
        .I_NR31_WR      (nr31_wr),
        .I_NR31_DATA    (nr31_data),
        .I_NR34_WR      (nr34_wr),
        .I_NR34_DATA    (nr34_data),
        .O_FS_STEP      (fs_step),
        .O_LENGTH_TICK  (length_tick),
        .O_SWEEP_TICK   (sweep_tick),
        .O_ENV_TICK     (env_tick),
        .O_CH3_TRIGGER  (ch3_trigger),
        .O_CH3_ON       (ch3_on),
        .O_LENGTH_COUNT (length_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        int  base;
        int  s;
        bit  trg;
        bit  dec;
        if (!rst_l || !apu) begin
            n_pwr = 0; m_count = 0; m_step = 0; m_len_en = 0; m_on = 0;
            m_trig = 0; m_lt = 0; m_st = 0; m_et = 0;
        end else begin
            n_pwr++;
            trg  = nr34_wr && nr34_data[7];
            base = nr31_wr ? 256 - int'(nr31_data) : m_count;
            dec  = m_lt && m_len_en && (m_count > 0) && !nr31_wr && !trg;
            if (trg && base == 0) base = 256;
            if (dec) base = m_count - 1;
            if (trg) m_on = dac;
            if (dec && base == 0) m_on = 0;
            if (!dac) m_on = 0;
            m_count = base;
            m_trig  = trg;
            if (nr34_wr) m_len_en = nr34_data[6];
            m_lt = 0; m_st = 0; m_et = 0;
            if (n_pwr % DIV == 0) begin
                s = (n_pwr / DIV - 1) % 8;
                m_lt = (s % 2 == 0);
                m_st = (s == 2) || (s == 6);
                m_et = (s == 7);
            end
            m_step = (n_pwr / DIV) % 8;
        end
    endtask

    function automatic logic [16:0] dut_vec();
        return {fs_step, length_tick, sweep_tick, env_tick, ch3_trigger, ch3_on, length_count};
    endfunction

    function automatic logic [16:0] model_vec();
        return {3'(m_step), m_lt, m_st, m_et, m_trig, m_on, 9'(m_count)};
    endfunction

    task automatic clk_step(input logic w31, input logic [7:0] d31,
                            input logic w34, input logic [7:0] d34);
        nr31_wr = w31; nr31_data = d31; nr34_wr = w34; nr34_data = d34;
        model_edge();
        @(posedge clk);
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
        nr31_wr = 1'b0; nr34_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_step(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic wait_lt();
        int g;
        g = 0;
        while (length_tick !== 1'b1 && g < 64) begin
            idle(1);
            g++;
        end
        check("wait_length_tick", 32'(length_tick), 32'd1);
    endtask

    initial begin
        int lt_n, st_n, et_n, saved;
        int r;

        // Reset state
        rst_l = 1'b0;
        idle(3);
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        rst_l = 1'b1;

        // Free-running sequencer over 64 cycles
        lt_n = 0; st_n = 0; et_n = 0;
        for (int i = 1; i <= 64; i++) begin
            idle(1);
            lt_n += int'(length_tick);
            st_n += int'(sweep_tick);
            et_n += int'(env_tick);
            if (i == 4)  check("first_length_tick", 32'(length_tick), 32'd1);
            if (i == 32) check("first_env_tick", 32'(env_tick), 32'd1);
        end
        check("length_tick_count", 32'(lt_n), 32'd8);
        check("sweep_tick_count", 32'(st_n), 32'd4);
        check("env_tick_count", 32'(et_n), 32'd2);

        // Length expiry: NR31=0xFC then trigger with length enabled
        clk_step(1'b1, 8'hFC, 1'b0, 8'h00);
        clk_step(1'b0, 8'h00, 1'b1, 8'hC0);
        check("trig_count4", 32'(length_count), 32'd4);
        check("trig_on", 32'(ch3_on), 32'd1);
        check("trig_strobe", 32'(ch3_trigger), 32'd1);
        idle(40);
        check("expired_count", 32'(length_count), 32'd0);
        check("expired_on", 32'(ch3_on), 32'd0);

        // Reload at zero with length disabled, hold through 300 length ticks
        clk_step(1'b0, 8'h00, 1'b1, 8'h80);
        check("reload_256", 32'(length_count), 32'd256);
        idle(300 * 2 * DIV);
        check("hold_count", 32'(length_count), 32'd256);
        check("hold_on", 32'(ch3_on), 32'd1);

        // NR31 load and trigger landing on a length-tick cycle
        clk_step(1'b0, 8'h00, 1'b1, 8'h40);
        wait_lt();
        clk_step(1'b1, 8'h00, 1'b0, 8'h00);
        check("nr31_beats_dec", 32'(length_count), 32'd256);
        clk_step(1'b1, 8'd251, 1'b0, 8'h00);
        wait_lt();
        clk_step(1'b0, 8'h00, 1'b1, 8'hC0);
        check("trig_beats_dec", 32'(length_count), 32'd5);

        // DAC off
        dac = 1'b0;
        clk_step(1'b0, 8'h00, 1'b1, 8'h80);
        check("dacoff_trig_on", 32'(ch3_on), 32'd0);
        check("dacoff_trig_strobe", 32'(ch3_trigger), 32'd1);
        dac = 1'b1;
        clk_step(1'b0, 8'h00, 1'b1, 8'h80);
        saved = m_count;
        dac = 1'b0;
        idle(1);
        check("dacoff_on", 32'(ch3_on), 32'd0);
        check("dacoff_count", 32'(length_count), 32'(saved));
        dac = 1'b1;

        // Power off mid-count, then power on
        clk_step(1'b1, 8'd219, 1'b0, 8'h00);
        clk_step(1'b0, 8'h00, 1'b1, 8'h80);
        check("count37", 32'(length_count), 32'd37);
        apu = 1'b0;
        idle(1);
        check("poweroff_outputs", 32'(dut_vec()), 32'd0);
        clk_step(1'b0, 8'h00, 1'b1, 8'hC0);
        check("poweroff_write_ignored", 32'(dut_vec()), 32'd0);
        apu = 1'b1;
        idle(DIV - 1);
        check("poweron_no_early_tick", 32'(length_tick), 32'd0);
        idle(1);
        check("poweron_first_tick", 32'(length_tick), 32'd1);

        // Reset mid-step
        clk_step(1'b0, 8'h00, 1'b1, 8'hC0);
        idle(5);
        rst_l = 1'b0;
        idle(1);
        check("midreset_outputs", 32'(dut_vec()), 32'd0);
        rst_l = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 50) dac = ~dac;
            if (r == 51) apu = ~apu;
            rst_l = (r != 52);
            if (r < 6)
                clk_step(1'b1, 8'($urandom), 1'b0, 8'h00);
            else if (r < 14)
                clk_step(1'b0, 8'h00, 1'b1, 8'($urandom));
            else if (r == 14)
                clk_step(1'b1, 8'($urandom), 1'b1, 8'($urandom));
            else
                idle(1);
            if (r == 53) apu = 1'b1;
        end
        rst_l = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
